// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths and constants for the memory arbiter
package mem_arbiter_pkg;
  localparam int DATA_W = 16;
  localparam logic [1:0] BYTES_ALL = 2'b11;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction/data) arbiter onto one memory port, data priority with round-robin on completion
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [19:1]       instr_m_addr,
  output logic [DATA_W-1:0] instr_m_data_in,
  input  logic              instr_m_access,
  output logic              instr_m_ack,
  input  logic [19:1]       data_m_addr,
  output logic [DATA_W-1:0] data_m_data_in,
  input  logic [DATA_W-1:0] data_m_data_out,
  input  logic              data_m_access,
  output logic              data_m_ack,
  input  logic              data_m_wr_en,
  input  logic [1:0]        data_m_bytesel,
  output logic [19:1]       q_m_addr,
  input  logic [DATA_W-1:0] q_m_data_in,
  output logic [DATA_W-1:0] q_m_data_out,
  output logic              q_m_access,
  input  logic              q_m_ack,
  output logic              q_m_wr_en,
  output logic [1:0]        q_m_bytesel
);
  typedef enum logic [1:0] {IDLE, SERVE_INSTR, SERVE_DATA} state_e;
  state_e state_q, state_d;
  logic is_i, is_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  // On completion the served master is skipped so the other one cannot starve
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = data_m_access ? SERVE_DATA : instr_m_access ? SERVE_INSTR : IDLE;
      SERVE_INSTR: state_d = !instr_m_access ? IDLE : q_m_ack ? (data_m_access ? SERVE_DATA : IDLE) : SERVE_INSTR;
      SERVE_DATA:  state_d = !data_m_access ? IDLE : q_m_ack ? (instr_m_access ? SERVE_INSTR : IDLE) : SERVE_DATA;
      default:     state_d = IDLE;
    endcase
  end
  always_comb begin
    is_i = state_q == SERVE_INSTR;
    is_d = state_q == SERVE_DATA;
    q_m_access = (is_i & instr_m_access) | (is_d & data_m_access);
    q_m_addr = is_d ? data_m_addr : is_i ? instr_m_addr : '0;
    q_m_wr_en = is_d & data_m_wr_en;
    q_m_bytesel = is_d ? data_m_bytesel : is_i ? BYTES_ALL : 2'b00;
    q_m_data_out = is_d ? data_m_data_out : '0;
    instr_m_ack = is_i & q_m_ack;
    data_m_ack = is_d & q_m_ack;
    instr_m_data_in = q_m_data_in;
    data_m_data_in = q_m_data_in;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, muxing, ack routing, alternation and reset
module tb_mem_arbiter;
  logic clk = 0, reset = 1;
  logic [19:1] instr_m_addr = '0, data_m_addr = '0, q_m_addr;
  logic [15:0] instr_m_data_in, data_m_data_in, data_m_data_out = '0, q_m_data_in = '0, q_m_data_out;
  logic instr_m_access = 0, instr_m_ack, data_m_access = 0, data_m_ack, data_m_wr_en = 0;
  logic [1:0] data_m_bytesel = '0, q_m_bytesel;
  logic q_m_access, q_m_ack = 0, q_m_wr_en;
  int n_chk = 0, n_pass = 0;
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_data_in(instr_m_data_in),
    .instr_m_access(instr_m_access), .instr_m_ack(instr_m_ack),
    .data_m_addr(data_m_addr), .data_m_data_in(data_m_data_in),
    .data_m_data_out(data_m_data_out), .data_m_access(data_m_access),
    .data_m_ack(data_m_ack), .data_m_wr_en(data_m_wr_en), .data_m_bytesel(data_m_bytesel),
    .q_m_addr(q_m_addr), .q_m_data_in(q_m_data_in), .q_m_data_out(q_m_data_out),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    q_m_data_in = 16'hA5A5;
    #1;
    chk("rst_access", q_m_access, 0);
    chk("rst_addr", q_m_addr, 0);
    chk("rst_acks", {instr_m_ack, data_m_ack}, 0);
    chk("rst_idata", instr_m_data_in, 16'hA5A5);
    chk("rst_ddata", data_m_data_in, 16'hA5A5);
    tick; reset = 0;
    // instruction-only transfer
    instr_m_access = 1; instr_m_addr = 19'h00100; #1;
    chk("i_lat0", q_m_access, 0);
    tick;
    chk("i_access", q_m_access, 1);
    chk("i_addr", q_m_addr, 19'h00100);
    chk("i_bytesel", q_m_bytesel, 2'b11);
    chk("i_wr", q_m_wr_en, 0);
    chk("i_dout", q_m_data_out, 0);
    chk("i_noack", {instr_m_ack, data_m_ack}, 0);
    tick; tick; q_m_ack = 1; #1;
    chk("i_ack", {instr_m_ack, data_m_ack}, 2'b10);
    tick; q_m_ack = 0; instr_m_access = 0; #1;
    chk("i_idle", q_m_access, 0);
    chk("i_ack_off", {instr_m_ack, data_m_ack}, 0);
    // simultaneous: data write first, then instr with no gap
    instr_m_access = 1; instr_m_addr = 19'h00200;
    data_m_access = 1; data_m_addr = 19'h12345; data_m_data_out = 16'hBEEF;
    data_m_bytesel = 2'b01; data_m_wr_en = 1;
    tick;
    chk("d_addr", q_m_addr, 19'h12345);
    chk("d_dout", q_m_data_out, 16'hBEEF);
    chk("d_bytesel", q_m_bytesel, 2'b01);
    chk("d_wr", q_m_wr_en, 1);
    q_m_ack = 1; #1;
    chk("d_ack", {instr_m_ack, data_m_ack}, 2'b01);
    tick; q_m_ack = 0; data_m_access = 0; #1;
    chk("s_i_addr", q_m_addr, 19'h00200);
    chk("s_i_access", q_m_access, 1);
    chk("s_i_wr", q_m_wr_en, 0);
    q_m_ack = 1; #1;
    chk("s_i_ack", {instr_m_ack, data_m_ack}, 2'b10);
    tick; q_m_ack = 0; instr_m_access = 0; data_m_wr_en = 0;
    // alternation with both masters requesting continuously
    instr_m_addr = 19'h00300; data_m_addr = 19'h00400;
    instr_m_access = 1; data_m_access = 1;
    for (int i = 0; i < 10; i++) begin
      tick; q_m_ack = 1; #1;
      chk($sformatf("alt%0d_addr", i), q_m_addr, (i % 2 == 0) ? 19'h00400 : 19'h00300);
      chk($sformatf("alt%0d_ack", i), {instr_m_ack, data_m_ack}, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    tick; q_m_ack = 0; instr_m_access = 0; #1;
    chk("alt_next", q_m_addr, 19'h00400);
    data_m_access = 0; #1;
    chk("drop_access", q_m_access, 0);
    tick; data_m_access = 1; #1;
    chk("drop_idle", q_m_access, 0);
    // same master back-to-back has one idle cycle
    tick; q_m_ack = 1; #1;
    chk("b2b_ack", data_m_ack, 1);
    tick; q_m_ack = 0; #1;
    chk("b2b_gap", q_m_access, 0);
    tick;
    chk("b2b_regrant", q_m_access, 1);
    // reset between edges abandons the transfer
    #2 reset = 1; q_m_ack = 1; #1;
    chk("mid_rst_access", q_m_access, 0);
    chk("mid_rst_ack", {instr_m_ack, data_m_ack}, 0);
    tick; reset = 0; data_m_access = 0; #1;
    chk("post_rst_idle", q_m_access, 0);
    // stray ack in idle
    q_m_data_in = 16'h1234; #1;
    chk("stray_ack", {instr_m_ack, data_m_ack}, 0);
    chk("passthru", data_m_data_in, 16'h1234);
    tick; q_m_ack = 0; instr_m_access = 1; #1;
    chk("stray_state", q_m_access, 0);
    tick;
    chk("stray_then_grant", q_m_bytesel, 2'b11);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
